// File: rtl/mult16_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult16_seq_pkg;

   localparam int MULT_W = 16;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage : mult16_seq_pkg

// File: rtl/mult16_seq_add16_carry.sv
// 16-bit ripple-carry adder with carry out: half adder at bit 0, full adders above.
module add16_carry
   import mult16_seq_pkg::*;
(
   input  logic [MULT_W-1:0] a,
   input  logic [MULT_W-1:0] b,
   output logic [MULT_W-1:0] s,
   output logic              cout
);

   logic [MULT_W:0] c;

   assign c[0] = 1'b0;

   genvar i;
   generate
      for (i = 0; i < MULT_W; i++) begin : g_bit
         if (i == 0) begin : g_ha
            assign s[i]   = a[i] ^ b[i];
            assign c[i+1] = a[i] & b[i];
         end else begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
         end
      end
   endgenerate

   assign cout = c[MULT_W];

endmodule : add16_carry

// File: rtl/mult16_seq.sv
// Sequential unsigned multiplier: one add-and-shift per cycle, 16 iterations,
// registered product with a one-cycle done pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; busy=0
// S_RUN  | iterating over multiplier bits; busy=1
// S_DONE | one cycle, product just written to p; done=1; may restart
module mult16_seq
   import mult16_seq_pkg::*;
#(
   parameter int WIDTH = MULT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   add_s;
   logic               add_cout;
   logic [WIDTH:0]     sum;

   add16_carry u_add (
      .a    (hi_q),
      .b    (m_q),
      .s    (add_s),
      .cout (add_cout)
   );

   // Partial-product sum: add the multiplicand only when the current multiplier bit is set.
   always_comb begin
      sum = lo_q[0] ? {add_cout, add_s} : {1'b0, hi_q};
   end

   // Next-state and datapath update; busy/done are computed for the state being entered.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               m_d     = a;
               lo_d    = b;
               hi_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               p_d     = {sum, lo_q[WIDTH-1:1]};
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Single state register for FSM, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule : mult16_seq

// File: tb/tb_mult16_seq.sv
// Self-checking bench for mult16_seq against a plain-arithmetic product model.
module tb_mult16_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] p;

   int vectors     = 0;
   int miscompares = 0;

   mult16_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mult(input logic [15:0] x, input logic [15:0] y);
      return 32'(x) * 32'(y);
   endfunction

   // Pulse start for one accepting edge, scramble operands while running, and
   // observe latency, busy cycles, busy/done overlap and early p changes.
   task automatic do_mult(input logic [15:0] av, input logic [15:0] bv,
                          output int lat, output logic [31:0] pres,
                          output int bcnt, output bit overlap, output bit pearly);
      logic [31:0] pprev;
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      pprev = p;
      lat = -1; bcnt = 0; overlap = 1'b0; pearly = 1'b0; pres = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if (busy && done) overlap = 1'b1;
         if (done) begin
            lat  = c;
            pres = p;
            break;
         end
         if (busy) bcnt++;
         if (p !== pprev) pearly = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (p !== 32'h0) begin miscompares++; $display("FAIL reset_p got %h want 00000000", p); end
   endtask

   task automatic test_basic;
      int lat, bcnt; logic [31:0] pr; bit ov, pe;
      do_mult(16'd3, 16'd5, lat, pr, bcnt, ov, pe);
      vectors++; if (lat !== 17) begin miscompares++; $display("FAIL basic_latency got %0d want 17", lat); end
      vectors++; if (bcnt !== 16) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 16", bcnt); end
      vectors++; if (pr !== 32'h0000000F) begin miscompares++; $display("FAIL basic_p got %h want 0000000f", pr); end
      vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL basic_overlap got %b want 0", ov); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL basic_idle busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_carry;
      int lat, bcnt; logic [31:0] pr; bit ov, pe;
      do_mult(16'hFFFF, 16'hFFFF, lat, pr, bcnt, ov, pe);
      vectors++; if (pr !== 32'hFFFE0001) begin miscompares++; $display("FAIL carry_p got %h want fffe0001", pr); end
      vectors++; if (lat !== 17) begin miscompares++; $display("FAIL carry_latency got %0d want 17", lat); end
   endtask

   task automatic test_hold;
      int lat, bcnt; logic [31:0] pr; bit ov, pe;
      do_mult(16'h8000, 16'h0002, lat, pr, bcnt, ov, pe);
      vectors++; if (pr !== 32'h00010000) begin miscompares++; $display("FAIL hold_first_p got %h want 00010000", pr); end
      do_mult(16'h0000, 16'h1234, lat, pr, bcnt, ov, pe);
      vectors++; if (pe !== 1'b0) begin miscompares++; $display("FAIL hold_p_early_change got %b want 0", pe); end
      vectors++; if (pr !== 32'h0) begin miscompares++; $display("FAIL hold_zero_p got %h want 00000000", pr); end
      repeat (4) @(negedge clk);
      vectors++; if (p !== 32'h0) begin miscompares++; $display("FAIL hold_idle_p got %h want 00000000", p); end
   endtask

   task automatic test_back_to_back;
      int dn[$];
      logic [31:0] pr[$];
      int c, d0, d1;
      logic [31:0] p0, p1;
      @(negedge clk);
      start = 1'b1; a = 16'd7; b = 16'd9;
      @(posedge clk);
      c = 0;
      while (dn.size() < 2 && c < 60) begin
         @(negedge clk);
         c++;
         if (done) begin
            dn.push_back(c);
            pr.push_back(p);
            if (dn.size() == 1) begin a = 16'd100; b = 16'd200; end
            else start = 1'b0;
         end else begin
            a = 16'($urandom);
            b = 16'($urandom);
         end
      end
      start = 1'b0;
      d0 = (dn.size() > 0) ? dn[0] : -1;
      d1 = (dn.size() > 1) ? dn[1] : -1;
      p0 = (pr.size() > 0) ? pr[0] : 32'hDEAD_BEEF;
      p1 = (pr.size() > 1) ? pr[1] : 32'hDEAD_BEEF;
      vectors++; if (d0 !== 17) begin miscompares++; $display("FAIL b2b_first_done got %0d want 17", d0); end
      vectors++; if (d1 !== 34) begin miscompares++; $display("FAIL b2b_second_done got %0d want 34", d1); end
      vectors++; if (p0 !== ref_mult(16'd7, 16'd9)) begin miscompares++; $display("FAIL b2b_first_p got %0d want 63", p0); end
      vectors++; if (p1 !== ref_mult(16'd100, 16'd200)) begin miscompares++; $display("FAIL b2b_second_p got %0d want 20000", p1); end
   endtask

   task automatic test_reset_mid;
      int lat, bcnt; logic [31:0] pr; bit ov, pe;
      int seen_done;
      @(negedge clk);
      start = 1'b1; a = 16'h1234; b = 16'h5678;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b want 0", done); end
      vectors++; if (p !== 32'h0) begin miscompares++; $display("FAIL midrst_p got %h want 00000000", p); end
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL midrst_no_activity got %0d want 0", seen_done); end
      do_mult(16'h1234, 16'h5678, lat, pr, bcnt, ov, pe);
      vectors++; if (pr !== 32'h06260060) begin miscompares++; $display("FAIL midrst_fresh_p got %h want 06260060", pr); end
      vectors++; if (lat !== 17) begin miscompares++; $display("FAIL midrst_fresh_latency got %0d want 17", lat); end
   endtask

   task automatic test_random;
      int lat, bcnt; logic [31:0] pr, exp; bit ov, pe;
      logic [15:0] x, y;
      for (int i = 0; i < 24; i++) begin
         case (i)
            0: begin x = 16'hFFFF; y = 16'h0001; end
            1: begin x = 16'h0001; y = 16'hFFFF; end
            2: begin x = 16'hAAAA; y = 16'h5555; end
            default: begin x = 16'($urandom); y = 16'($urandom); end
         endcase
         do_mult(x, y, lat, pr, bcnt, ov, pe);
         exp = ref_mult(x, y);
         vectors++;
         if (pr !== exp || lat !== 17 || bcnt !== 16 || ov !== 1'b0 || pe !== 1'b0) begin
            miscompares++;
            $display("FAIL random_%0d %h*%h got p=%h lat=%0d busy=%0d ov=%b early=%b want p=%h lat=17 busy=16 ov=0 early=0",
                     i, x, y, pr, lat, bcnt, ov, pe, exp);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_carry;
      test_hold;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mult16_seq
